wb_dcache_assoc_ctrl: RTL and testbench

WB_DCACHE_ASSOC_CTRL -- requirements
Module: wb_dcache_assoc_ctrl

---
 rtl/wb_dcache_assoc_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_wb_dcache_assoc_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dcache_assoc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dcache_assoc_ctrl
//  Description : Set-associative write-back data cache controller. Serves
//                LSU/MMU hits, evicts dirty victims, refills lines by beat
//                bursts and walks every (set, way) for a full flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_dcache_assoc_ctrl #(
  parameter int NUM_WAYS       = 2,
  parameter int NUM_SETS       = 64,
  parameter int BEATS_PER_LINE = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                lsummu2dcache_req_i,
  input  logic                                lsummu2dcache_wr_i,
  input  logic                                dmem_sel_i,
  output logic                                dcache2lsummu_ack_o,
  input  logic [NUM_WAYS-1:0]                 cache_hit_way_i,
  input  logic [NUM_WAYS-1:0]                 cache_valid_way_i,
  input  logic [NUM_WAYS-1:0]                 cache_dirty_way_i,
  output logic [NUM_WAYS-1:0]                 cache_way_sel_o,
  output logic                                cache_wr_o,
  output logic                                cache_line_wr_o,
  output logic                                cache_writeback_req_o,
  output logic                                cache_clean_o,
  output logic [$clog2(BEATS_PER_LINE)-1:0]   beat_idx_o,
  input  logic                                flush_req_i,
  output logic                                flush_ack_o,
  output logic                                flush_active_o,
  output logic [$clog2(NUM_SETS)-1:0]         flush_set_idx_o,
  input  logic                                mem2dcache_ack_i,
  output logic                                dcache2mem_req_o,
  output logic                                dcache2mem_wr_o,
  output logic                                dcache2mem_last_o
);

  localparam int BEAT_W = $clog2(BEATS_PER_LINE);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);

  localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);
  localparam logic [SET_W-1:0]  C_LAST_SET  = SET_W'(NUM_SETS - 1);
  localparam logic [WAY_W-1:0]  C_LAST_WAY  = WAY_W'(NUM_WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_READ        = 3'd1,
    S_WRITE       = 3'd2,
    S_WRITE_BACK  = 3'd3,
    S_ALLOCATE    = 3'd4,
    S_FLUSH_CHECK = 3'd5,
    S_FLUSH_WB    = 3'd6,
    S_FLUSH_DONE  = 3'd7
  } state_t;

  state_t               r_state;
  logic                 r_lsu_ack;
  logic                 r_cache_wr;
  logic                 r_wb_req;
  logic                 r_mem_req;
  logic                 r_mem_wr;
  logic                 r_flush_ack;
  logic                 r_flush_active;
  logic                 r_used_rr;     // victim came from the round-robin pointer
  logic                 r_abort;       // select dropped during the write-back burst
  logic [NUM_WAYS-1:0]  r_way_sel;
  logic [BEAT_W-1:0]    r_beat;
  logic [SET_W-1:0]     r_set;
  logic [WAY_W-1:0]     r_fway;
  logic [WAY_W-1:0]     r_rr_ptr;

  logic                 w_lsu_go;
  logic                 w_any_hit;
  logic                 w_beat_done;
  logic                 w_last_beat;
  logic                 w_flush_last;
  logic                 w_flush_dirty;
  logic                 w_inv_found;
  logic [WAY_W-1:0]     w_victim_idx;
  logic [NUM_WAYS-1:0]  w_victim_oh;
  logic                 w_victim_dirty;

  assign w_lsu_go      = lsummu2dcache_req_i & dmem_sel_i;
  assign w_any_hit     = |cache_hit_way_i;
  // Only a burst state holds r_mem_req high, so stray memory acks are ignored
  assign w_beat_done   = r_mem_req & mem2dcache_ack_i;
  assign w_last_beat   = (r_beat == C_LAST_BEAT);
  assign w_flush_last  = (r_set == C_LAST_SET) && (r_fway == C_LAST_WAY);
  assign w_flush_dirty = cache_valid_way_i[r_fway] & cache_dirty_way_i[r_fway];

  // Victim choice: lowest-index invalid way, otherwise the round-robin pointer
  always_comb begin
    w_victim_idx = r_rr_ptr;
    w_inv_found  = 1'b0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!cache_valid_way_i[i]) begin
        w_victim_idx = WAY_W'(i);
        w_inv_found  = 1'b1;
      end
    end
  end

  assign w_victim_oh    = NUM_WAYS'(1) << w_victim_idx;
  assign w_victim_dirty = cache_valid_way_i[w_victim_idx] & cache_dirty_way_i[w_victim_idx];

  // Controller FSM with registered outputs and burst/flush counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= S_IDLE;
      r_lsu_ack      <= 1'b0;
      r_cache_wr     <= 1'b0;
      r_wb_req       <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_wr       <= 1'b0;
      r_flush_ack    <= 1'b0;
      r_flush_active <= 1'b0;
      r_used_rr      <= 1'b0;
      r_abort        <= 1'b0;
      r_way_sel      <= '0;
      r_beat         <= '0;
      r_set          <= '0;
      r_fway         <= '0;
      r_rr_ptr       <= '0;
    end else begin
      r_lsu_ack   <= 1'b0;
      r_cache_wr  <= 1'b0;
      r_flush_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_way_sel <= '0;
          if (flush_req_i) begin
            r_state        <= S_FLUSH_CHECK;
            r_flush_active <= 1'b1;
            r_set          <= '0;
            r_fway         <= '0;
          end else if (w_lsu_go) begin
            if (w_any_hit) begin
              r_way_sel <= cache_hit_way_i;
              r_lsu_ack <= 1'b1;
              if (lsummu2dcache_wr_i) begin
                r_cache_wr <= 1'b1;
                r_state    <= S_WRITE;
              end else begin
                r_state <= S_READ;
              end
            end else begin
              r_way_sel <= w_victim_oh;
              r_used_rr <= ~w_inv_found;
              r_abort   <= 1'b0;
              r_beat    <= '0;
              r_mem_req <= 1'b1;
              if (w_victim_dirty) begin
                r_mem_wr <= 1'b1;
                r_wb_req <= 1'b1;
                r_state  <= S_WRITE_BACK;
              end else begin
                r_state <= S_ALLOCATE;
              end
            end
          end
        end
        S_READ, S_WRITE: begin
          r_way_sel <= '0;
          r_state   <= S_IDLE;
        end
        S_WRITE_BACK: begin
          if (!dmem_sel_i) r_abort <= 1'b1;
          if (w_beat_done) begin
            if (w_last_beat) begin
              r_beat   <= '0;
              r_wb_req <= 1'b0;
              r_mem_wr <= 1'b0;
              // A dropped select ends the transaction once the line is out
              if (r_abort || !dmem_sel_i) begin
                r_mem_req <= 1'b0;
                r_way_sel <= '0;
                r_state   <= S_IDLE;
              end else begin
                r_state <= S_ALLOCATE;
              end
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        S_ALLOCATE: begin
          if (w_beat_done) begin
            if (w_last_beat) begin
              r_beat    <= '0;
              r_mem_req <= 1'b0;
              r_way_sel <= '0;
              r_state   <= S_IDLE;
              if (r_used_rr) r_rr_ptr <= r_rr_ptr + WAY_W'(1);
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        S_FLUSH_CHECK: begin
          if (w_flush_dirty) begin
            r_way_sel <= NUM_WAYS'(1) << r_fway;
            r_beat    <= '0;
            r_mem_req <= 1'b1;
            r_mem_wr  <= 1'b1;
            r_wb_req  <= 1'b1;
            r_state   <= S_FLUSH_WB;
          end else if (w_flush_last) begin
            r_flush_ack <= 1'b1;
            r_state     <= S_FLUSH_DONE;
          end else begin
            r_fway <= r_fway + WAY_W'(1);
            if (r_fway == C_LAST_WAY) r_set <= r_set + SET_W'(1);
          end
        end
        S_FLUSH_WB: begin
          if (w_beat_done) begin
            if (w_last_beat) begin
              r_beat    <= '0;
              r_mem_req <= 1'b0;
              r_mem_wr  <= 1'b0;
              r_wb_req  <= 1'b0;
              r_way_sel <= '0;
              if (w_flush_last) begin
                r_flush_ack <= 1'b1;
                r_state     <= S_FLUSH_DONE;
              end else begin
                r_fway  <= r_fway + WAY_W'(1);
                if (r_fway == C_LAST_WAY) r_set <= r_set + SET_W'(1);
                r_state <= S_FLUSH_CHECK;
              end
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        S_FLUSH_DONE: begin
          r_flush_active <= 1'b0;
          r_set          <= '0;
          r_fway         <= '0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // LSU-facing strobes are squashed as soon as the memory select goes away
  assign dcache2lsummu_ack_o   = r_lsu_ack & dmem_sel_i;
  assign cache_wr_o            = r_cache_wr & dmem_sel_i;
  assign cache_way_sel_o       = r_way_sel;
  // Refill data and dirty clear happen in the cycle the memory beat lands
  assign cache_line_wr_o       = (r_state == S_ALLOCATE) & mem2dcache_ack_i;
  assign cache_clean_o         = (r_state == S_FLUSH_WB) & mem2dcache_ack_i & w_last_beat;
  assign cache_writeback_req_o = r_wb_req;
  assign beat_idx_o            = r_beat;
  assign flush_ack_o           = r_flush_ack;
  assign flush_active_o        = r_flush_active;
  assign flush_set_idx_o       = r_set;
  assign dcache2mem_req_o      = r_mem_req;
  assign dcache2mem_wr_o       = r_mem_wr;
  assign dcache2mem_last_o     = r_mem_req & w_last_beat;

endmodule
`default_nettype wire

// File: tb/tb_wb_dcache_assoc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_dcache_assoc_ctrl
//  Description : Directed and randomized bench for wb_dcache_assoc_ctrl with
//                a transaction-level reference model of victim choice,
//                round-robin replacement, bursts and flush walking.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_dcache_assoc_ctrl;

  localparam int NW    = 2;
  localparam int NS    = 4;
  localparam int BEATS = 4;
  localparam int BW    = 2;
  localparam int SW    = 2;
  localparam logic [11:0] C_NO_SEL = 12'hFFC;

  logic          clk_i;
  logic          rst_ni;
  logic          lsu_req, lsu_wr, dmem_sel, lsu_ack;
  logic [NW-1:0] hit_i, valid_i, dirty_i, way_sel;
  logic          cache_wr, line_wr, wb_req, clean;
  logic [BW-1:0] beat_idx;
  logic          flush_req, flush_ack, flush_active;
  logic [SW-1:0] flush_set;
  logic          mem_ack, mem_req, mem_wr, mem_last;

  int total = 0;
  int bad   = 0;
  int rr_ptr = 0;

  wb_dcache_assoc_ctrl #(.NUM_WAYS(NW), .NUM_SETS(NS), .BEATS_PER_LINE(BEATS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsummu2dcache_req_i(lsu_req), .lsummu2dcache_wr_i(lsu_wr),
    .dmem_sel_i(dmem_sel), .dcache2lsummu_ack_o(lsu_ack),
    .cache_hit_way_i(hit_i), .cache_valid_way_i(valid_i), .cache_dirty_way_i(dirty_i),
    .cache_way_sel_o(way_sel), .cache_wr_o(cache_wr), .cache_line_wr_o(line_wr),
    .cache_writeback_req_o(wb_req), .cache_clean_o(clean), .beat_idx_o(beat_idx),
    .flush_req_i(flush_req), .flush_ack_o(flush_ack), .flush_active_o(flush_active),
    .flush_set_idx_o(flush_set), .mem2dcache_ack_i(mem_ack),
    .dcache2mem_req_o(mem_req), .dcache2mem_wr_o(mem_wr), .dcache2mem_last_o(mem_last)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] obs_bus();
    return {mem_req, mem_wr, wb_req, mem_last, line_wr, clean, lsu_ack, cache_wr, beat_idx, way_sel};
  endfunction

  function automatic logic [11:0] exp_bus(input bit mreq, input bit mwr, input bit wbr, input bit last,
                                          input bit lwr, input bit cln, input bit ack, input bit cwr,
                                          input int beat, input logic [NW-1:0] ws);
    return {mreq, mwr, wbr, last, lwr, cln, ack, cwr, BW'(beat), ws};
  endfunction

  function automatic logic [15:0] all_outs();
    return {obs_bus(), flush_ack, flush_active, flush_set};
  endfunction

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  // One line burst: random wait states before each beat's memory ack
  task automatic burst(input bit wb, input int way, input bit flush, input int drop_beat,
                       input int stop_beat, output bit stopped);
    logic [NW-1:0] oh;
    oh = NW'(1) << way;
    stopped = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      int w;
      w = int'($urandom_range(2, 0));
      if (b == stop_beat) stopped = 1'b1;
      if (b == drop_beat) dmem_sel = 1'b0;
      for (int k = 0; k <= w && !stopped; k++) begin
        mem_ack = (k == w);
        #1;
        chk("burst", obs_bus(), exp_bus(1'b1, wb, wb, b == BEATS - 1, !wb && mem_ack,
                                         flush && mem_ack && (b == BEATS - 1), 1'b0, 1'b0, b, oh));
        next_cyc();
      end
    end
    mem_ack = 1'b0;
  endtask

  // One LSU access from IDLE; a miss is followed by the repeated lookup hit
  task automatic do_access(input bit wr, input logic [NW-1:0] hit, input logic [NW-1:0] valid,
                           input logic [NW-1:0] dirty, input int drop_beat);
    int v;
    bit used_ptr, dirty_v, st;
    lsu_req = 1'b1; lsu_wr = wr; dmem_sel = 1'b1;
    hit_i = hit; valid_i = valid; dirty_i = dirty;
    mem_ack = 1'($urandom_range(1, 0));
    #1;
    chk("idle_pre", obs_bus() & C_NO_SEL, 12'h0);
    next_cyc();
    mem_ack = 1'b0;
    if (hit != '0) begin
      lsu_req = 1'b0;
      #1;
      chk("hit_ack", obs_bus(), exp_bus(0, 0, 0, 0, 0, 0, 1, wr, 0, hit));
      next_cyc();
      #1;
      chk("hit_done", obs_bus() & C_NO_SEL, 12'h0);
    end else begin
      v = -1;
      for (int i = 0; i < NW; i++) if (!valid[i] && v < 0) v = i;
      used_ptr = (v < 0);
      if (used_ptr) v = rr_ptr;
      dirty_v = valid[v] && dirty[v];
      hit_i = '0;
      if (dirty_v) burst(1'b1, v, 1'b0, -1, -1, st);
      burst(1'b0, v, 1'b0, drop_beat, -1, st);
      if (used_ptr) rr_ptr = (rr_ptr + 1) % NW;
      hit_i = NW'(1) << v;
      #1;
      chk("refill_idle", obs_bus() & C_NO_SEL, 12'h0);
      next_cyc();
      lsu_req = 1'b0;
      #1;
      if (drop_beat >= 0) chk("drop_noack", obs_bus() & C_NO_SEL, 12'h0);
      else chk("refill_hit", obs_bus(), exp_bus(0, 0, 0, 0, 0, 0, 1, wr, 0, NW'(1) << v));
      next_cyc();
      #1;
      chk("miss_done", obs_bus() & C_NO_SEL, 12'h0);
    end
    dmem_sel = 1'b1;
  endtask

  // Full flush against a per-(set,way) dirty map; LSU traffic must be ignored
  task automatic do_flush(input logic [NS*NW-1:0] dmap);
    bit st;
    flush_req = 1'b1; lsu_req = 1'b1; dmem_sel = 1'b1; hit_i = 2'b01;
    lsu_wr = 1'($urandom_range(1, 0));
    #1;
    chk("flush_idle", obs_bus() & C_NO_SEL, 12'h0);
    next_cyc();
    flush_req = 1'b0;
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin
        valid_i = '1;
        dirty_i = dmap[s*NW +: NW];
        dmem_sel = 1'($urandom_range(1, 0));
        #1;
        chk("fchk", {mem_req, lsu_ack, cache_wr, clean, flush_active, flush_ack, flush_set},
            {4'b0000, 1'b1, 1'b0, SW'(s)});
        next_cyc();
        if (dmap[s*NW + w]) begin
          #1;
          chk("fwb_set", {flush_active, flush_set}, {1'b1, SW'(s)});
          burst(1'b1, w, 1'b1, -1, -1, st);
        end
      end
    end
    lsu_req = 1'b0;
    #1;
    chk("fdone", {obs_bus() & C_NO_SEL, flush_active, flush_ack}, {12'h0, 1'b1, 1'b1});
    next_cyc();
    #1;
    chk("fidle", {obs_bus() & C_NO_SEL, flush_active, flush_ack, flush_set}, {12'h0, 2'b00, 2'b00});
    dmem_sel = 1'b1;
  endtask

  initial begin
    bit st;
    logic [NW-1:0] rh;
    rst_ni = 1'b0; lsu_req = 1'b0; lsu_wr = 1'b0; dmem_sel = 1'b0;
    hit_i = '0; valid_i = '0; dirty_i = '0; flush_req = 1'b0; mem_ack = 1'b0;
    #3;
    chk("reset", all_outs(), 16'h0);
    next_cyc();
    rst_ni = 1'b1;
    next_cyc();

    // Read hit way1, write hit way0
    do_access(1'b0, 2'b10, 2'b11, 2'b00, -1);
    do_access(1'b1, 2'b01, 2'b11, 2'b00, -1);
    // Dirty miss with pointer 0, then pointer-driven clean miss on way1
    do_access(1'b0, 2'b00, 2'b11, 2'b01, -1);
    do_access(1'b1, 2'b00, 2'b11, 2'b00, -1);
    // Invalid way1 chosen first, pointer untouched; then pointer victim way0
    do_access(1'b0, 2'b00, 2'b01, 2'b01, -1);
    do_access(1'b0, 2'b00, 2'b11, 2'b10, -1);

    // Select dropped during READ and WRITE: strobes squashed
    for (int i = 0; i < 2; i++) begin
      lsu_req = 1'b1; lsu_wr = 1'(i); dmem_sel = 1'b1; hit_i = 2'b01;
      next_cyc();
      lsu_req = 1'b0; dmem_sel = 1'b0;
      #1;
      chk("sel_drop_hit", obs_bus() & C_NO_SEL, 12'h0);
      next_cyc();
      dmem_sel = 1'b1;
      #1;
      chk("sel_drop_idle", obs_bus() & C_NO_SEL, 12'h0);
    end

    // Select dropped at refill beat 1: burst still completes, no ack
    do_access(1'b0, 2'b00, 2'b11, 2'b00, 1);

    // Request without select is never accepted
    lsu_req = 1'b1; dmem_sel = 1'b0; hit_i = 2'b10;
    next_cyc();
    #1;
    chk("nosel_idle", obs_bus() & C_NO_SEL, 12'h0);
    lsu_req = 1'b0; dmem_sel = 1'b1;
    next_cyc();

    // Flush: only set2 way0 dirty, then a random dirty map
    do_flush(8'b0001_0000);
    do_flush(8'($urandom));

    // Randomized accesses against the model
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(3, 0))
        0: rh = 2'b01;
        1: rh = 2'b10;
        default: rh = 2'b00;
      endcase
      do_access(1'($urandom_range(1, 0)), rh, 2'($urandom), 2'($urandom), -1);
    end

    // Asynchronous reset at write-back beat 2
    lsu_req = 1'b1; lsu_wr = 1'b0; dmem_sel = 1'b1; hit_i = '0; valid_i = 2'b11; dirty_i = 2'b11;
    next_cyc();
    burst(1'b1, rr_ptr, 1'b0, -1, 2, st);
    #1;
    chk("pre_rst", {mem_req, beat_idx}, {1'b1, 2'd2});
    rst_ni = 1'b0; lsu_req = 1'b0;
    #1;
    chk("rst_async", all_outs(), 16'h0);
    next_cyc();
    rst_ni = 1'b1;
    rr_ptr = 0;
    #1;
    chk("rst_release", all_outs(), 16'h0);
    next_cyc();
    do_access(1'b0, 2'b10, 2'b11, 2'b00, -1);
    do_access(1'b1, 2'b00, 2'b11, 2'b00, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
